// File: rtl/debug_dmi_regs.sv
// ============================================================================
//  Module   : debug_dmi_regs
//  Purpose  : Debug Module register block behind a DMI request/response
//             channel. Holds data0, dmcontrol, dmstatus, hartinfo,
//             abstractcs and command, drives halt/resume/reset requests to a
//             single hart and hands abstract commands to an executor.
//  Ports    : clk, rst                      - clock, async active-high reset
//             dmi_req_* / dmi_rsp_*         - DMI request / response channel
//             hart_halted/running/resumeack - hart status inputs
//             hart_haltreq/resumereq        - hart run-control requests
//             ndmreset, dmactive            - system reset / DM active levels
//             cmd_valid, cmd                - abstract command issue
//             cmd_done, cmd_err             - abstract command completion
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module debug_dmi_regs (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmi_req_valid,
    output logic        dmi_req_ready,
    input  logic [6:0]  dmi_req_addr,
    input  logic [1:0]  dmi_req_op,
    input  logic [31:0] dmi_req_data,
    output logic        dmi_rsp_valid,
    input  logic        dmi_rsp_ready,
    output logic [31:0] dmi_rsp_data,
    output logic [1:0]  dmi_rsp_op,
    input  logic        hart_halted,
    input  logic        hart_running,
    input  logic        hart_resumeack,
    output logic        hart_haltreq,
    output logic        hart_resumereq,
    output logic        ndmreset,
    output logic        dmactive,
    output logic        cmd_valid,
    output logic [31:0] cmd,
    input  logic        cmd_done,
    input  logic [2:0]  cmd_err
);

    localparam logic [6:0] c_addr_data0      = 7'h04;
    localparam logic [6:0] c_addr_dmcontrol  = 7'h10;
    localparam logic [6:0] c_addr_dmstatus   = 7'h11;
    localparam logic [6:0] c_addr_hartinfo   = 7'h12;
    localparam logic [6:0] c_addr_abstractcs = 7'h16;
    localparam logic [6:0] c_addr_command    = 7'h17;

    localparam logic [1:0] c_op_read   = 2'd1;
    localparam logic [1:0] c_op_write  = 2'd2;
    localparam logic [1:0] c_op_rsvd   = 2'd3;
    localparam logic [1:0] c_rsp_fail  = 2'd2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_rsp_data;
    logic [1:0]  r_rsp_op;
    logic [31:0] r_data0;
    logic [31:0] r_cmd;
    logic        r_cmd_valid;
    logic        r_haltreq;
    logic        r_resumereq;
    logic        r_resumeack;
    logic        r_ndmreset;
    logic        r_dmactive;
    logic        r_busy;
    logic [2:0]  r_cmderr;

    logic        w_accept;
    logic        w_write;
    logic [31:0] w_dmcontrol;
    logic [31:0] w_dmstatus;
    logic [31:0] w_abstractcs;
    logic [31:0] w_rdata;
    logic [31:0] w_rsp_data;
    logic [1:0]  w_rsp_op;

    assign w_accept = (r_state == ST_IDLE) && dmi_req_valid;
    assign w_write  = w_accept && (dmi_req_op == c_op_write);

    // resumereq is a write-only trigger, so it is not reflected back
    assign w_dmcontrol  = {r_haltreq, 1'b0, 28'd0, r_ndmreset, r_dmactive};

    assign w_dmstatus   = {9'd0, 1'b0, 2'd0, 2'd0,
                           r_resumeack, r_resumeack,
                           4'd0,
                           hart_running, hart_running,
                           hart_halted, hart_halted,
                           1'b1, 3'd0, 4'd2};

    assign w_abstractcs = {3'd0, 5'd0, 11'd0, r_busy, 1'b0, r_cmderr, 4'd0, 4'd1};

    // Read mux sees only pre-edge state, so a read never observes a write
    // accepted on the same edge. command reads back as zero.
    always_comb begin
        w_rdata = 32'd0;
        case (dmi_req_addr)
            c_addr_data0:      w_rdata = r_data0;
            c_addr_dmcontrol:  w_rdata = w_dmcontrol;
            c_addr_dmstatus:   w_rdata = w_dmstatus;
            c_addr_hartinfo:   w_rdata = 32'd0;
            c_addr_abstractcs: w_rdata = w_abstractcs;
            default:           w_rdata = 32'd0;
        endcase
    end

    always_comb begin
        w_rsp_data = 32'd0;
        w_rsp_op   = 2'd0;
        if (dmi_req_op == c_op_read) begin
            w_rsp_data = w_rdata;
        end else if (dmi_req_op == c_op_rsvd) begin
            w_rsp_op = c_rsp_fail;
        end
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        dmi_req_ready = 1'b0;
        dmi_rsp_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                dmi_req_ready = 1'b1;
                if (dmi_req_valid) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                dmi_rsp_valid = 1'b1;
                if (dmi_rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath
    // Statement order matters: later assignments win, so a DMI write that
    // touches cmderr/busy takes precedence over the completion path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_data  <= 32'd0;
            r_rsp_op    <= 2'd0;
            r_data0     <= 32'd0;
            r_cmd       <= 32'd0;
            r_cmd_valid <= 1'b0;
            r_haltreq   <= 1'b0;
            r_resumereq <= 1'b0;
            r_resumeack <= 1'b0;
            r_ndmreset  <= 1'b0;
            r_dmactive  <= 1'b0;
            r_busy      <= 1'b0;
            r_cmderr    <= 3'd0;
        end else begin
            r_cmd_valid <= 1'b0;

            if (w_accept) begin
                r_rsp_data <= w_rsp_data;
                r_rsp_op   <= w_rsp_op;
            end

            if (r_resumereq && hart_resumeack) begin
                r_resumereq <= 1'b0;
                r_resumeack <= 1'b1;
            end

            if (cmd_done && r_busy) begin
                r_busy <= 1'b0;
                if ((cmd_err != 3'd0) && (r_cmderr == 3'd0)) begin
                    r_cmderr <= cmd_err;
                end
            end

            if (w_write) begin
                case (dmi_req_addr)
                    c_addr_data0: begin
                        if (r_busy) begin
                            if (r_cmderr == 3'd0) r_cmderr <= 3'd1;
                        end else begin
                            r_data0 <= dmi_req_data;
                        end
                    end
                    c_addr_dmcontrol: begin
                        if (!dmi_req_data[0]) begin
                            r_dmactive  <= 1'b0;
                            r_haltreq   <= 1'b0;
                            r_ndmreset  <= 1'b0;
                            r_resumereq <= 1'b0;
                            r_data0     <= 32'd0;
                            r_cmd       <= 32'd0;
                            r_cmderr    <= 3'd0;
                        end else begin
                            r_dmactive <= 1'b1;
                            r_haltreq  <= dmi_req_data[31];
                            r_ndmreset <= dmi_req_data[1];
                            // a resume request is meaningless alongside a halt request
                            if (dmi_req_data[30] && !dmi_req_data[31]) begin
                                r_resumereq <= 1'b1;
                                r_resumeack <= 1'b0;
                            end
                        end
                    end
                    c_addr_abstractcs: begin
                        r_cmderr <= r_cmderr & ~dmi_req_data[10:8];
                    end
                    c_addr_command: begin
                        if (r_busy) begin
                            if (r_cmderr == 3'd0) r_cmderr <= 3'd1;
                        end else if (r_cmderr == 3'd0) begin
                            r_cmd       <= dmi_req_data;
                            r_cmd_valid <= 1'b1;
                            r_busy      <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign dmi_rsp_data   = r_rsp_data;
    assign dmi_rsp_op     = r_rsp_op;
    assign hart_haltreq   = r_haltreq;
    assign hart_resumereq = r_resumereq;
    assign ndmreset       = r_ndmreset;
    assign dmactive       = r_dmactive;
    assign cmd_valid      = r_cmd_valid;
    assign cmd            = r_cmd;

endmodule

`default_nettype wire

// File: tb/tb_debug_dmi_regs.sv
// ============================================================================
//  Module   : tb_debug_dmi_regs
//  Purpose  : Self-checking bench for debug_dmi_regs: a table of DMI
//             transactions with hand-computed responses, followed by directed
//             sequences for resume handshake, abstract command busy/error
//             handling, completion/write collisions, back-pressure and reset.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_debug_dmi_regs;

    logic        clk;
    logic        rst;
    logic        dmi_req_valid;
    logic        dmi_req_ready;
    logic [6:0]  dmi_req_addr;
    logic [1:0]  dmi_req_op;
    logic [31:0] dmi_req_data;
    logic        dmi_rsp_valid;
    logic        dmi_rsp_ready;
    logic [31:0] dmi_rsp_data;
    logic [1:0]  dmi_rsp_op;
    logic        hart_halted;
    logic        hart_running;
    logic        hart_resumeack;
    logic        hart_haltreq;
    logic        hart_resumereq;
    logic        ndmreset;
    logic        dmactive;
    logic        cmd_valid;
    logic [31:0] cmd;
    logic        cmd_done;
    logic [2:0]  cmd_err;

    debug_dmi_regs dut (
        .clk            (clk),
        .rst            (rst),
        .dmi_req_valid  (dmi_req_valid),
        .dmi_req_ready  (dmi_req_ready),
        .dmi_req_addr   (dmi_req_addr),
        .dmi_req_op     (dmi_req_op),
        .dmi_req_data   (dmi_req_data),
        .dmi_rsp_valid  (dmi_rsp_valid),
        .dmi_rsp_ready  (dmi_rsp_ready),
        .dmi_rsp_data   (dmi_rsp_data),
        .dmi_rsp_op     (dmi_rsp_op),
        .hart_halted    (hart_halted),
        .hart_running   (hart_running),
        .hart_resumeack (hart_resumeack),
        .hart_haltreq   (hart_haltreq),
        .hart_resumereq (hart_resumereq),
        .ndmreset       (ndmreset),
        .dmactive       (dmactive),
        .cmd_valid      (cmd_valid),
        .cmd            (cmd),
        .cmd_done       (cmd_done),
        .cmd_err        (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic        halted;
        logic        running;
        logic [31:0] exp_data;
        logic [1:0]  exp_op;
        logic        exp_haltreq;
        logic        exp_ndmreset;
        logic        exp_dmactive;
    } vec_t;

    localparam int c_nvec = 16;
    vec_t vecs [c_nvec];

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] rd_data;
    logic [1:0]  rd_op;
    logic        cv_snap;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // One complete DMI transaction: request accepted on one edge, response
    // sampled one cycle later, then released with rsp_ready for one edge.
    task automatic txn(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] wdata,
                       input logic done, input logic [2:0] err);
        @(negedge clk);
        check("req_ready_idle", {31'd0, dmi_req_ready}, 32'd1);
        dmi_req_valid = 1'b1;
        dmi_req_op    = op;
        dmi_req_addr  = addr;
        dmi_req_data  = wdata;
        cmd_done      = done;
        cmd_err       = err;
        @(posedge clk);
        #1;
        dmi_req_valid = 1'b0;
        cmd_done      = 1'b0;
        cmd_err       = 3'd0;
        check("rsp_valid_lat1", {31'd0, dmi_rsp_valid}, 32'd1);
        rd_data = dmi_rsp_data;
        rd_op   = dmi_rsp_op;
        cv_snap = cmd_valid;
        dmi_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        dmi_rsp_ready = 1'b0;
        check("rsp_valid_drop", {31'd0, dmi_rsp_valid}, 32'd0);
    endtask

    task automatic rd(input logic [6:0] addr, input string name, input logic [31:0] exp);
        txn(2'd1, addr, 32'd0, 1'b0, 3'd0);
        check(name, rd_data, exp);
    endtask

    task automatic wr(input logic [6:0] addr, input logic [31:0] wdata);
        txn(2'd2, addr, wdata, 1'b0, 3'd0);
    endtask

    task automatic pulse_done(input logic [2:0] err);
        @(negedge clk);
        cmd_done = 1'b1;
        cmd_err  = err;
        @(negedge clk);
        cmd_done = 1'b0;
        cmd_err  = 3'd0;
    endtask

    initial begin
        // op, addr, wdata, halted, running, exp_data, exp_op, haltreq, ndmreset, dmactive
        vecs[0]  = '{2'd1, 7'h11, 32'h0,        1'b0, 1'b1, 32'h00000C82, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{2'd2, 7'h10, 32'h80000001, 1'b0, 1'b1, 32'h0,        2'd0, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{2'd1, 7'h11, 32'h0,        1'b1, 1'b0, 32'h00000382, 2'd0, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{2'd2, 7'h04, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0,        2'd0, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{2'd1, 7'h04, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF, 2'd0, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{2'd1, 7'h12, 32'h0,        1'b1, 1'b0, 32'h0,        2'd0, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{2'd1, 7'h16, 32'h0,        1'b1, 1'b0, 32'h00000001, 2'd0, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{2'd1, 7'h55, 32'h0,        1'b1, 1'b0, 32'h0,        2'd0, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{2'd3, 7'h04, 32'h12345678, 1'b1, 1'b0, 32'h0,        2'd2, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{2'd1, 7'h04, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF, 2'd0, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{2'd0, 7'h04, 32'h0,        1'b1, 1'b0, 32'h0,        2'd0, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{2'd2, 7'h55, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0,        2'd0, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{2'd2, 7'h10, 32'h80000003, 1'b1, 1'b0, 32'h0,        2'd0, 1'b1, 1'b1, 1'b1};
        vecs[13] = '{2'd2, 7'h10, 32'h00000000, 1'b1, 1'b0, 32'h0,        2'd0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{2'd1, 7'h04, 32'h0,        1'b0, 1'b1, 32'h0,        2'd0, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{2'd2, 7'h10, 32'h00000001, 1'b0, 1'b1, 32'h0,        2'd0, 1'b0, 1'b0, 1'b1};

        rst            = 1'b1;
        dmi_req_valid  = 1'b0;
        dmi_req_addr   = 7'd0;
        dmi_req_op     = 2'd0;
        dmi_req_data   = 32'd0;
        dmi_rsp_ready  = 1'b0;
        hart_halted    = 1'b0;
        hart_running   = 1'b0;
        hart_resumeack = 1'b0;
        cmd_done       = 1'b0;
        cmd_err        = 3'd0;

        // ---------------------------------------------------- reset state
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", {31'd0, dmi_rsp_valid}, 32'd0);
        check("rst_rsp_data", dmi_rsp_data, 32'd0);
        check("rst_rsp_op", {30'd0, dmi_rsp_op}, 32'd0);
        check("rst_sideband", {26'd0, hart_haltreq, hart_resumereq, ndmreset, dmactive, cmd_valid, 1'b0}, 32'd0);
        check("rst_cmd", cmd, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", {31'd0, dmi_req_ready}, 32'd1);

        // ------------------------------------------------- vector table
        for (int i = 0; i < c_nvec; i++) begin
            hart_halted  = vecs[i].halted;
            hart_running = vecs[i].running;
            txn(vecs[i].op, vecs[i].addr, vecs[i].wdata, 1'b0, 3'd0);
            check($sformatf("vec%0d_data", i), rd_data, vecs[i].exp_data);
            check($sformatf("vec%0d_op", i), {30'd0, rd_op}, {30'd0, vecs[i].exp_op});
            check($sformatf("vec%0d_ctl", i), {29'd0, hart_haltreq, ndmreset, dmactive},
                  {29'd0, vecs[i].exp_haltreq, vecs[i].exp_ndmreset, vecs[i].exp_dmactive});
        end

        // ------------------------------------------- resume handshake
        hart_halted  = 1'b0;
        hart_running = 1'b1;
        wr(7'h10, 32'h40000001);
        check("resumereq_set", {31'd0, hart_resumereq}, 32'd1);
        repeat (3) @(negedge clk);
        check("resumereq_held", {31'd0, hart_resumereq}, 32'd1);
        rd(7'h11, "dmstatus_no_ack", 32'h00000C82);
        @(negedge clk);
        hart_resumeack = 1'b1;
        @(negedge clk);
        hart_resumeack = 1'b0;
        check("resumereq_drop", {31'd0, hart_resumereq}, 32'd0);
        rd(7'h11, "dmstatus_ack", 32'h00030C82);
        hart_halted  = 1'b1;
        hart_running = 1'b0;
        wr(7'h10, 32'hC0000001);
        check("resume_ignored_halt", {30'd0, hart_haltreq, hart_resumereq}, 32'h2);
        rd(7'h11, "dmstatus_ack_kept", 32'h00030382);
        wr(7'h10, 32'h00000001);
        check("haltreq_cleared", {31'd0, hart_haltreq}, 32'd0);

        // ------------------------------------ abstract command / busy
        wr(7'h17, 32'h00221000);
        check("cmd_valid_pulse", {31'd0, cv_snap}, 32'd1);
        check("cmd_valid_one", {31'd0, cmd_valid}, 32'd0);
        check("cmd_stored", cmd, 32'h00221000);
        rd(7'h16, "acs_busy", 32'h00001001);
        wr(7'h17, 32'h12345678);
        check("cmd_busy_no_pulse", {31'd0, cv_snap}, 32'd0);
        check("cmd_busy_kept", cmd, 32'h00221000);
        rd(7'h16, "acs_busy_err", 32'h00001101);
        wr(7'h04, 32'h55555555);
        rd(7'h04, "data0_busy_drop", 32'h0);
        wr(7'h16, 32'h00000700);
        rd(7'h16, "acs_w1c", 32'h00001001);

        // ---------------------------------------- completion / errors
        pulse_done(3'd3);
        rd(7'h16, "acs_done_err3", 32'h00000301);
        wr(7'h17, 32'h11111111);
        check("cmd_err_silent", {31'd0, cv_snap}, 32'd0);
        check("cmd_err_kept", cmd, 32'h00221000);
        rd(7'h16, "acs_err_kept", 32'h00000301);
        wr(7'h16, 32'h00000700);
        rd(7'h16, "acs_clear", 32'h00000001);
        pulse_done(3'd5);
        rd(7'h16, "acs_done_idle", 32'h00000001);

        // ------------------------- completion coincident with a write
        wr(7'h17, 32'hAAAA0000);
        check("cmd2_pulse", {31'd0, cv_snap}, 32'd1);
        txn(2'd2, 7'h17, 32'hBBBB0000, 1'b1, 3'd0);
        check("coinc_no_pulse", {31'd0, cv_snap}, 32'd0);
        check("coinc_cmd_kept", cmd, 32'hAAAA0000);
        rd(7'h16, "coinc_acs", 32'h00000101);

        // -------------------------------- back-pressure, then reset
        wr(7'h04, 32'hCAFEF00D);
        @(negedge clk);
        dmi_req_valid = 1'b1;
        dmi_req_op    = 2'd1;
        dmi_req_addr  = 7'h04;
        @(posedge clk);
        #1;
        dmi_req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall%0d_valid", i), {31'd0, dmi_rsp_valid}, 32'd1);
            check($sformatf("stall%0d_data", i), dmi_rsp_data, 32'hCAFEF00D);
            check($sformatf("stall%0d_ready", i), {31'd0, dmi_req_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_in_resp_valid", {31'd0, dmi_rsp_valid}, 32'd0);
        check("rst_in_resp_data", dmi_rsp_data, 32'd0);
        @(negedge clk);
        check("rst2_sideband", {27'd0, hart_haltreq, hart_resumereq, ndmreset, dmactive, cmd_valid}, 32'd0);
        check("rst2_cmd", cmd, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst2_no_rsp", {31'd0, dmi_rsp_valid}, 32'd0);
        rd(7'h04, "rst2_data0", 32'h0);
        rd(7'h16, "rst2_acs", 32'h00000001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/debug_dmi_regs.md
DEBUG_DMI_REGS -- requirements
Module: debug_dmi_regs

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: dmi_req_valid in 1, dmi_req_ready out 1, dmi_req_addr in 7, dmi_req_op in 2 (0 nop, 1 read, 2 write, 3 reserved), dmi_req_data in 32.
REQ-004 SHALL have ports: dmi_rsp_valid out 1, dmi_rsp_ready in 1, dmi_rsp_data out 32, dmi_rsp_op out 2 (0 ok, 2 failed).
REQ-005 SHALL have ports: hart_halted in 1, hart_running in 1, hart_resumeack in 1, hart_haltreq out 1, hart_resumereq out 1, ndmreset out 1, dmactive out 1.
REQ-006 SHALL have ports: cmd_valid out 1, cmd out 32 (command_t), cmd_done in 1, cmd_err in 3.

Function
REQ-007 SHALL run a two-state FSM: IDLE (dmi_req_ready=1) and RESP (dmi_req_ready=0, dmi_rsp_valid=1).
REQ-008 IDLE->RESP on dmi_req_valid; response data/op registered that edge; rsp_valid asserted next cycle (latency 1).
REQ-009 RESP->IDLE on dmi_rsp_ready; dmi_rsp_data/op SHALL hold stable while in RESP.
REQ-010 Register map: 0x04 data0, 0x10 dmcontrol, 0x11 dmstatus, 0x12 hartinfo (reads 0), 0x16 abstractcs, 0x17 command; other addresses read 0, writes ignored, rsp_op 0.
REQ-011 op 0 SHALL respond data 0, op 0; op 3 SHALL respond data 0, op 2, no side effects.
REQ-012 Read data SHALL reflect state before any write in the same cycle; writes respond data 0.
REQ-013 dmcontrol write with active=0 SHALL clear haltreq, ndmreset, resumereq, data0, command, abstractcs.cmderr; dmactive=0.
REQ-014 dmcontrol write with active=1 SHALL latch haltreq (bit31) and ndmreset (bit1) as levels driven to hart_haltreq/ndmreset.
REQ-015 resumereq (bit30)=1 with haltreq=0 SHALL clear resumeack flag and raise hart_resumereq until hart_resumeack, then drop it and set resumeack flag; ignored if haltreq=1.
REQ-016 dmstatus SHALL read version=2, authenticated=1, allhalted/anyhalted=hart_halted, allrunning/anyrunning=hart_running, allresumeack/anyresumeack=resumeack flag, impebreak=0, all other bits 0.
REQ-017 abstractcs SHALL read datacount=1 [3:0], cmderr [10:8], busy [12], progbufsize=0; writes to [10:8] are write-1-to-clear.
REQ-018 command write with busy=0 and cmderr=0 SHALL store cmd, pulse cmd_valid one cycle, set busy.
REQ-019 command or data0 write with busy=1 SHALL be dropped and set cmderr=1 if cmderr=0; command write with cmderr!=0 SHALL be dropped silently.
REQ-020 cmd_done SHALL clear busy; if cmd_err!=0 and cmderr=0, cmderr<=cmd_err.
REQ-021 cmd_done coincident with a DMI write SHALL have the write evaluated against busy=1 (pre-edge value).
REQ-022 cmd_done while busy=0 SHALL be ignored.
REQ-023 data0 SHALL be 32-bit read/write storage, also forwarded nowhere else.

Reset
REQ-024 On rst: FSM IDLE, dmi_req_ready=1 after release, dmi_rsp_valid=0, dmi_rsp_data=0, dmi_rsp_op=0.
REQ-025 On rst: hart_haltreq=0, hart_resumereq=0, ndmreset=0, dmactive=0, cmd_valid=0, cmd=0, busy=0, cmderr=0, data0=0, resumeack flag=0.
REQ-026 rst mid-transaction SHALL drop any pending response; no response is issued for it.

Verification
REQ-027 Write 0x10=0x80000001 -> hart_haltreq=1, dmactive=1; read 0x11 with hart_halted=1 -> data 0x00000382, rsp 1 cycle after accept.
REQ-028 haltreq=0, write 0x10=0x40000001 -> hart_resumereq=1 until hart_resumeack pulse; read 0x11 then has bits 17:16 set.
REQ-029 Write 0x17=0x00221000 -> cmd_valid one cycle, abstractcs busy=1; second write -> cmderr=1; write 0x16=0x00000700 -> cmderr=0.
REQ-030 cmd_done with cmd_err=3 -> abstractcs reads 0x00000301; read 0x55 -> data 0, op 0; op 3 -> op 2.
REQ-031 Hold dmi_rsp_ready=0 for 5 cycles -> rsp data stable, req_ready=0; assert rst in RESP -> rsp_valid=0 same cycle.
